// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: data-memory size encoding, FSM states, request decode helpers.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE,
        ALIGNED,
        BYTE,
        RESP
    } lsu_state_e;

    // Request size 2'b11 is an alias for word.
    function automatic mem_size_e decode_size(input logic [1:0] size);
        return size[1] ? SZ_WORD : mem_size_e'(size);
    endfunction

    function automatic logic is_aligned(input mem_size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return !addr_lo[0];
            default: return addr_lo == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Sign/zero extension of an assembled load value (module lsu_extend).
module lsu_extend
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  mem_size_e             size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] ext_c
);

    always_comb begin
        ext_c = data;
        case (size)
            SZ_BYTE: ext_c = is_unsigned ? {{(DATA_WIDTH-8){1'b0}}, data[7:0]}
                                         : {{(DATA_WIDTH-8){data[7]}}, data[7:0]};
            SZ_HALF: ext_c = is_unsigned ? {{(DATA_WIDTH-16){1'b0}}, data[15:0]}
                                         : {{(DATA_WIDTH-16){data[15]}}, data[15:0]};
            default: ext_c = data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: aligned accesses in one memory cycle; misaligned ones split into byte
// accesses when LSU_MISALIGN_EN is defined, otherwise rejected with resp_err_o.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [1:0]            mem_size_o,
    output logic                  mem_unsigned_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    lsu_state_e state;
    mem_size_e  req_size;
    logic       req_aligned;

    assign req_size    = decode_size(req_size_i);
    assign req_aligned = is_aligned(req_size, req_addr_i[1:0]);

`ifdef LSU_MISALIGN_EN
    logic [1:0]            k;
    logic [1:0]            k_next_c;
    logic                  last_byte_c;
    mem_size_e             lat_size;
    logic                  lat_unsigned;
    logic [DATA_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_next_c;
    logic [DATA_WIDTH-1:0] ext_c;

    // Assembly register including the byte returned this cycle.
    always_comb begin
        asm_next_c = asm_q;
        asm_next_c[{k, 3'b000} +: 8] = mem_rdata_i[7:0];
        last_byte_c = (k == ((lat_size == SZ_HALF) ? 2'd1 : 2'd3));
        k_next_c    = k + 2'd1;
    end

    lsu_extend #(.DATA_WIDTH(DATA_WIDTH)) u_extend (
        .data        (asm_next_c),
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .ext_c       (ext_c)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req_ready_o    <= 1'b1;
            resp_valid_o   <= 1'b0;
            resp_err_o     <= 1'b0;
            resp_rdata_o   <= '0;
            mem_read_o     <= 1'b0;
            mem_write_o    <= 1'b0;
            mem_size_o     <= SZ_BYTE;
            mem_unsigned_o <= 1'b0;
            mem_addr_o     <= '0;
            mem_wdata_o    <= '0;
`ifdef LSU_MISALIGN_EN
            k              <= 2'd0;
            asm_q          <= '0;
            lat_size       <= SZ_BYTE;
            lat_unsigned   <= 1'b0;
            lat_addr       <= '0;
            lat_wdata      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
`ifdef LSU_MISALIGN_EN
                        lat_size     <= req_size;
                        lat_unsigned <= req_unsigned_i;
                        lat_addr     <= req_addr_i;
                        lat_wdata    <= req_wdata_i;
`endif
                        if (req_aligned) begin
                            state          <= ALIGNED;
                            mem_read_o     <= !req_write_i;
                            mem_write_o    <= req_write_i;
                            mem_size_o     <= req_size;
                            mem_unsigned_o <= req_unsigned_i;
                            mem_addr_o     <= req_addr_i;
                            mem_wdata_o    <= req_write_i ? req_wdata_i : '0;
                        end else begin
`ifdef LSU_MISALIGN_EN
                            state          <= BYTE;
                            k              <= 2'd0;
                            asm_q          <= '0;
                            mem_read_o     <= !req_write_i;
                            mem_write_o    <= req_write_i;
                            mem_size_o     <= SZ_BYTE;
                            mem_unsigned_o <= 1'b1;
                            mem_addr_o     <= req_addr_i;
                            mem_wdata_o    <= req_write_i ? DATA_WIDTH'(req_wdata_i[7:0]) : '0;
`else
                            state        <= RESP;
                            resp_valid_o <= 1'b1;
                            resp_err_o   <= 1'b1;
                            resp_rdata_o <= '0;
`endif
                        end
                    end
                end
                ALIGNED: begin
                    state          <= RESP;
                    resp_valid_o   <= 1'b1;
                    resp_err_o     <= 1'b0;
                    resp_rdata_o   <= mem_write_o ? '0 : mem_rdata_i;
                    mem_read_o     <= 1'b0;
                    mem_write_o    <= 1'b0;
                    mem_size_o     <= SZ_BYTE;
                    mem_unsigned_o <= 1'b0;
                    mem_addr_o     <= '0;
                    mem_wdata_o    <= '0;
                end
`ifdef LSU_MISALIGN_EN
                BYTE: begin
                    asm_q <= asm_next_c;
                    if (last_byte_c) begin
                        state          <= RESP;
                        resp_valid_o   <= 1'b1;
                        resp_err_o     <= 1'b0;
                        resp_rdata_o   <= mem_write_o ? '0 : ext_c;
                        mem_read_o     <= 1'b0;
                        mem_write_o    <= 1'b0;
                        mem_size_o     <= SZ_BYTE;
                        mem_unsigned_o <= 1'b0;
                        mem_addr_o     <= '0;
                        mem_wdata_o    <= '0;
                    end else begin
                        k           <= k_next_c;
                        mem_addr_o  <= lat_addr + DATA_WIDTH'(k_next_c);
                        mem_wdata_o <= mem_write_o ? DATA_WIDTH'(lat_wdata[{k_next_c, 3'b000} +: 8]) : '0;
                    end
                end
`endif
                RESP: begin
                    state        <= IDLE;
                    req_ready_o  <= 1'b1;
                    resp_valid_o <= 1'b0;
                    resp_err_o   <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array data memory, reference memory model with response
// queue, per-cycle compare process, and literal checks for the documented scenarios.
module tb_load_store_unit;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_write_i = 1'b0;
    logic [1:0]    req_size_i = 2'b00;
    logic          req_unsigned_i = 1'b0;
    logic [DW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0;
    logic          resp_valid_o;
    logic [DW-1:0] resp_rdata_o;
    logic          resp_err_o;
    logic          mem_read_o;
    logic          mem_write_o;
    logic [1:0]    mem_size_o;
    logic          mem_unsigned_o;
    logic [DW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_write_i    (req_write_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .resp_valid_o   (resp_valid_o),
        .resp_rdata_o   (resp_rdata_o),
        .resp_err_o     (resp_err_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .mem_size_o     (mem_size_o),
        .mem_unsigned_o (mem_unsigned_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Little-endian data memory; reads are combinational and extended per size/unsigned.
    always_comb begin
        logic [31:0] w;
        logic [7:0]  a;
        a = mem_addr_o[7:0];
        w = {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
        case (mem_size_o)
            2'b00:   mem_rdata_i = mem_unsigned_o ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            2'b01:   mem_rdata_i = mem_unsigned_o ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: mem_rdata_i = w;
        endcase
    end

    // A strobe coinciding with a reset edge is the aborted access and is not committed.
    always @(posedge clk) begin
        if (!rst && mem_write_o) begin
            for (int i = 0; i < size_bytes(mem_size_o); i++)
                mem[mem_addr_o[7:0] + 8'(i)] <= mem_wdata_o[8*i +: 8];
        end
    end

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    int unsigned cyc = 0;
    int unsigned idle_from = 0;
    int          errors = 0;
    int          checks = 0;
    int          resp_seen = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;
    int unsigned last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] w;
        w = {ref_mem[a[7:0] + 8'd3], ref_mem[a[7:0] + 8'd2], ref_mem[a[7:0] + 8'd1], ref_mem[a[7:0]]};
        if (sz == 2'b00) return uns ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
        if (sz == 2'b01) return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
        return w;
    endfunction

    // Per-cycle comparison against the model's expected responses and idle windows.
    always @(negedge clk) begin
        if (!rst) begin
            check("strobe_exclusive", 32'(mem_read_o && mem_write_o), 32'd0);
            check("req_ready", 32'(req_ready_o), 32'(cyc >= idle_from));
            if (cyc >= idle_from)
                check("idle_strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                check("resp_valid", 32'(resp_valid_o), 32'd1);
                check("resp_rdata", resp_rdata_o, expq[0].data);
                check("resp_err", 32'(resp_err_o), 32'(expq[0].err));
                last_rdata = resp_rdata_o;
                last_err   = resp_err_o;
                last_cyc   = cyc;
                resp_seen++;
                void'(expq.pop_front());
            end else begin
                check("resp_valid_quiet", 32'(resp_valid_o), 32'd0);
            end
        end
    end

    // Issues one request held for 'hold' edges; returns the cycle in which it was accepted.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         output int unsigned acc);
        exp_t e;
        int   nb;
        bit   aligned;
        @(negedge clk);
        req_write_i    = wr;
        req_size_i     = sz;
        req_unsigned_i = uns;
        req_addr_i     = a;
        req_wdata_i    = wd;
        req_valid_i    = 1'b1;
        @(posedge clk);
        #1;
        acc     = cyc - 1;
        nb      = size_bytes(sz);
        aligned = (a % nb) == 0;
        e.err   = 1'b0;
        if (aligned) e.cyc = acc + 2;
        else begin
`ifdef LSU_MISALIGN_EN
            e.cyc = acc + 32'(nb) + 1;
`else
            e.cyc = acc + 1;
            e.err = 1'b1;
`endif
        end
        if (wr && !e.err)
            for (int i = 0; i < nb; i++) ref_mem[a[7:0] + 8'(i)] = wd[8*i +: 8];
        e.data = (wr || e.err) ? 32'h0 : ref_load(a, sz, uns);
        expq.push_back(e);
        idle_from = e.cyc + 1;
        for (int h = 1; h < hold; h++) begin
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        for (int t = 0; t < 20 && expq.size() > 0; t++) @(posedge clk);
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: %0d responses outstanding at cycle %0d", expq.size(), cyc);
            expq.delete();
            idle_from = cyc;
        end
    endtask

    initial begin
        int unsigned acc;
        int          seen0;
        int          diff;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'h00;
            ref_mem[i] = 8'h00;
        end
        mem[8'h40] = 8'h78; mem[8'h41] = 8'h56; mem[8'h42] = 8'h34; mem[8'h43] = 8'h12;
        mem[8'h50] = 8'h80; mem[8'h61] = 8'h34; mem[8'h62] = 8'h92;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready_o), 32'd1);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_resp_err", 32'(resp_err_o), 32'd0);
        check("rst_rdata", resp_rdata_o, 32'd0);
        check("rst_strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
        check("rst_size_uns", 32'({mem_size_o, mem_unsigned_o}), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        rst = 1'b0;

        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1, acc);
        check("lw_0x40", last_rdata, 32'h1234_5678);
        check("lw_latency", last_cyc - acc, 32'd2);

        issue(1'b0, 2'b00, 1'b0, 32'h50, 32'h0, 1, acc);
        check("lb_0x50", last_rdata, 32'hFFFF_FF80);
        issue(1'b0, 2'b00, 1'b1, 32'h50, 32'h0, 1, acc);
        check("lbu_0x50", last_rdata, 32'h0000_0080);
        issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1, acc);
        check("lw_size11", last_rdata, 32'h1234_5678);
        issue(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 1, acc);
        check("lhu_0x42", last_rdata, 32'h0000_1234);

        issue(1'b1, 2'b01, 1'b0, 32'h48, 32'h0000_BEEF, 1, acc);
        check("sh_rdata_zero", last_rdata, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h48, 32'h0, 1, acc);
        check("lh_0x48", last_rdata, 32'hFFFF_BEEF);
        issue(1'b1, 2'b00, 1'b0, 32'h70, 32'h1234_565A, 1, acc);
        issue(1'b0, 2'b00, 1'b1, 32'h70, 32'h0, 1, acc);
        check("lbu_0x70", last_rdata, 32'h0000_005A);

        issue(1'b1, 2'b10, 1'b0, 32'h41, 32'hAABB_CCDD, 1, acc);
`ifdef LSU_MISALIGN_EN
        check("sw41_latency", last_cyc - acc, 32'd5);
        check("sw41_bytes", {mem[8'h44], mem[8'h43], mem[8'h42], mem[8'h41]}, 32'hAABB_CCDD);
        issue(1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 1, acc);
        check("lw_0x41", last_rdata, 32'hAABB_CCDD);
        check("lw41_latency", last_cyc - acc, 32'd5);
        issue(1'b0, 2'b01, 1'b0, 32'h61, 32'h0, 1, acc);
        check("lh_0x61", last_rdata, 32'hFFFF_9234);
        check("lh61_latency", last_cyc - acc, 32'd3);
        issue(1'b0, 2'b01, 1'b1, 32'h61, 32'h0, 1, acc);
        check("lhu_0x61", last_rdata, 32'h0000_9234);
`else
        check("sw41_err", 32'(last_err), 32'd1);
        check("sw41_no_write", 32'(mem[8'h41]), 32'h56);
        issue(1'b0, 2'b01, 1'b0, 32'h61, 32'h0, 1, acc);
        check("lh61_err", 32'(last_err), 32'd1);
        check("lh61_rdata", last_rdata, 32'h0);
        check("lh61_latency", last_cyc - acc, 32'd1);
`endif

        seen0 = resp_seen;
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 3, acc);
        repeat (3) @(posedge clk);
        check("busy_single_accept", 32'(resp_seen - seen0), 32'd1);

        // Reset in the middle of a store: misaligned byte k=1, or the single aligned cycle.
        @(negedge clk);
        req_write_i = 1'b1;
        req_unsigned_i = 1'b0;
        req_wdata_i = 32'h1122_3344;
        req_size_i = 2'b10;
`ifdef LSU_MISALIGN_EN
        req_addr_i = 32'h81;
`else
        req_addr_i = 32'h80;
`endif
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        idle_from = 32'hFFFF_FFFF;
`ifdef LSU_MISALIGN_EN
        @(posedge clk);
        #1;
        ref_mem[8'h81] = 8'h44;
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", 32'(req_ready_o), 32'd1);
        check("midrst_no_resp", 32'(resp_valid_o), 32'd0);
        check("midrst_strobes", 32'({mem_read_o, mem_write_o}), 32'd0);
        rst = 1'b0;
        idle_from = cyc;
        repeat (3) @(posedge clk);
`ifdef LSU_MISALIGN_EN
        check("midrst_byte0", 32'(mem[8'h81]), 32'h44);
        check("midrst_byte1", 32'(mem[8'h82]), 32'h00);
`else
        check("midrst_nowrite", 32'(mem[8'h80]), 32'h00);
`endif

        issue(1'b0, 2'b00, 1'b0, 32'h50, 32'h0, 1, acc);
        check("post_rst_lb", last_rdata, 32'hFFFF_FF80);

        diff = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== ref_mem[i]) diff++;
        check("mem_image_diffs", 32'(diff), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, data and address width.
REQ-002 Port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: req_valid_i  in  1  pipeline request present.
REQ-005 Port: req_ready_o  out  1  unit can accept a request this cycle.
REQ-006 Port: req_write_i  in  1  1 = store, 0 = load.
REQ-007 Port: req_size_i  in  2  access size: 00 = byte, 01 = halfword, 10 or 11 = word.
REQ-008 Port: req_unsigned_i  in  1  load result is zero-extended.
REQ-009 Port: req_addr_i  in  DATA_WIDTH  byte address.
REQ-010 Port: req_wdata_i  in  DATA_WIDTH  store data, LSB-aligned.
REQ-011 Port: resp_valid_o  out  1  one-cycle completion pulse.
REQ-012 Port: resp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores.
REQ-013 Port: resp_err_o  out  1  access rejected; qualified by resp_valid_o.
REQ-014 Port: mem_read_o / mem_write_o  out  1 each  data-memory strobes.
REQ-015 Port: mem_size_o  out  2  data-memory access size, same encoding as req_size_i.
REQ-016 Port: mem_unsigned_o  out  1  data-memory zero-extend select.
REQ-017 Port: mem_addr_o / mem_wdata_o  out  DATA_WIDTH  data-memory address and write data.
REQ-018 Port: mem_rdata_i  in  DATA_WIDTH  data-memory read data; combinational, valid in the same cycle as mem_read_o.

Function
REQ-019 FSM states SHALL be IDLE, ALIGNED, BYTE, RESP.
REQ-020 req_ready_o SHALL be 1 only in IDLE.
REQ-021 A request is accepted when req_valid_i && req_ready_o; all request fields SHALL be latched at that edge.
REQ-022 Alignment: byte is always aligned; halfword is aligned iff addr[0]=0; word is aligned iff addr[1:0]=00.
REQ-023 Aligned request: IDLE->ALIGNED for exactly one cycle, with one strobe driven; mem_size_o = latched size, mem_unsigned_o = latched unsigned, mem_addr_o = latched address.
REQ-024 ALIGNED load: mem_rdata_i SHALL be captured into the response register at the end of the ALIGNED cycle, unmodified.
REQ-025 Misaligned request: IDLE->BYTE; one byte access per cycle, for N = 2 (halfword) or N = 4 (word) cycles.
REQ-026 In BYTE, a 2-bit counter k runs 0..N-1; mem_size_o = 00, mem_unsigned_o = 1, mem_addr_o = addr+k.
REQ-027 BYTE store: mem_wdata_o = wdata byte k in bits [7:0].
REQ-028 BYTE load: mem_rdata_i[7:0] SHALL be placed into byte k of the assembly register.
REQ-029 After the last byte, the assembly register SHALL be sign- or zero-extended from 16 bits (halfword) or passed through (word).
REQ-030 Address arithmetic addr+k SHALL wrap modulo 2^DATA_WIDTH.
REQ-031 ALIGNED or last BYTE -> RESP; RESP asserts resp_valid_o for one cycle, then -> IDLE.
REQ-032 Latency from acceptance to resp_valid_o: 2 cycles aligned; N+1 cycles misaligned.
REQ-033 resp_valid_o has no backpressure; the next request can be accepted in the cycle after RESP.
REQ-034 mem_read_o and mem_write_o SHALL never both be 1, and SHALL both be 0 in IDLE and RESP.
REQ-035 req_valid_i in any non-IDLE state SHALL be ignored and not queued.

Reset
REQ-036 While rst is high at a clock edge: state -> IDLE, k -> 0, response and assembly registers -> 0.
REQ-037 Outputs after reset: req_ready_o = 1; resp_valid_o, resp_err_o, mem strobes, mem_size_o, mem_unsigned_o = 0; mem_addr_o, mem_wdata_o, resp_rdata_o = 0.
REQ-038 Reset mid-access SHALL abort the access with no response; bytes already stored remain written.

Configuration
REQ-039 Macro LSU_MISALIGN_EN defined: misaligned accesses are split as in REQ-025..029.
REQ-040 Macro LSU_MISALIGN_EN undefined: a misaligned request goes IDLE->RESP with no memory strobe, resp_err_o = 1 and resp_rdata_o = 0; the BYTE state and counter are absent.

Structure
REQ-041 Package lsu_pkg SHALL hold the mem_size_e encoding (BYTE = 00, HALF = 01, WORD = 10) and the lsu_state_e FSM enum; datamem-facing logic SHALL use the same encoding.
REQ-042 Sub-module lsu_extend SHALL hold the combinational sign/zero extension used in REQ-029.

Verification
REQ-043 Aligned word load: mem bytes 0x40..0x43 = 78 56 34 12, load word 0x40 -> resp_rdata_o = 0x12345678, 2 cycles after acceptance.
REQ-044 Signed byte load: byte 0x50 = 0x80 -> lb gives 0xFFFFFF80; lbu gives 0x00000080.
REQ-045 Misaligned word store then load (LSU_MISALIGN_EN defined): sw 0xAABBCCDD at 0x41 -> 4 byte writes DD, CC, BB, AA at 0x41..0x44; lw 0x41 returns 0xAABBCCDD, 5 cycles after acceptance.
REQ-046 Misaligned signed halfword load: bytes 0x61 = 0x34, 0x62 = 0x92 -> lh 0x61 gives 0xFFFF9234; with LSU_MISALIGN_EN undefined, the same request gives resp_err_o = 1, resp_rdata_o = 0, and no strobe.
REQ-047 Reset mid-access: assert rst during BYTE k = 1 of a misaligned sw -> next cycle state is IDLE and req_ready_o = 1, no resp_valid_o, only byte 0 written.
REQ-048 Busy drop: req_valid_i held high for 3 consecutive cycles -> exactly one request is accepted, and strobes are never both 1.
